// File: rtl/trumpet_pkg.sv
// Shared constants and recorder FSM encoding for the trumpet practice path.
// Used by both the capture path and the playback address generator.
package trumpet_pkg;

    localparam int unsigned DEF_ADDR_W = 14;
    localparam int unsigned DEF_DATA_W = 3;
    localparam int unsigned DEF_DEPTH  = 5001;
    localparam int unsigned DEF_DECIM  = 6;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StWrite   = 2'd2,
        StDone    = 2'd3
    } rec_state_e;

endpackage

// File: rtl/sample_quantizer.sv
// Combinational 32-bit signed sample -> DATA_W-bit RAM code.
// Truncates by default; AUDIO_RECORDER_ROUND_EN selects round-to-nearest with saturation.
module sample_quantizer
    import trumpet_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [31:0]       sample,
    output logic [DATA_W-1:0] code
);

`ifdef AUDIO_RECORDER_ROUND_EN
    localparam logic [32:0] HALF = 33'(1) << (31 - DATA_W);

    logic [32:0] sum;
    logic        unused_sum_low;

    assign sum            = {sample[31], sample} + HALF;
    assign unused_sum_low = ^sum[31-DATA_W:0];

    // Only a positive sample can carry into bit 31; clamp it to the largest positive code.
    always_comb begin
        if (!sum[32] && sum[31]) begin
            code = {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            code = sum[31:32-DATA_W];
        end
    end
`else
    logic unused_low;

    assign code       = sample[31:32-DATA_W];
    assign unused_low = ^sample[31-DATA_W:0];
`endif

endmodule

// File: rtl/audio_recorder.sv
// Capture path: drains the codec audio-in FIFO, keeps 1 of every DECIM left samples,
// quantizes and writes one DEPTH-word take into the sample RAM. Rounding: AUDIO_RECORDER_ROUND_EN.
module audio_recorder
    import trumpet_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned DECIM  = DEF_DECIM
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              start,
    input  logic              audio_in_available,
    input  logic [31:0]       left_channel_audio_in,
    output logic              read_audio_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sample_count
);

    localparam int unsigned       CNT_W      = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0]  DECIM_LAST = CNT_W'(DECIM - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);

    rec_state_e        state_q, state_d;
    logic [CNT_W-1:0]  decim_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] count_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] quant;
    logic              pop;
    logic              window_end;

    // The FIFO is drained in every state so the codec never overflows.
    assign read_audio_in = audio_in_available;
    assign pop           = audio_in_available;
    assign window_end    = pop && (decim_q == DECIM_LAST);

    assign ram_address  = addr_q;
    assign ram_data     = data_q;
    assign sample_count = count_q;

    sample_quantizer #(
        .DATA_W (DATA_W)
    ) u_quant (
        .sample (left_channel_audio_in),
        .code   (quant)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StCapture;
            StCapture:      if (window_end) state_d = StWrite;
            StWrite:        state_d = (addr_q == ADDR_LAST) ? StDone : StCapture;
            default:        state_d = StIdle;
        endcase
    end

    // Decoding from state_q keeps ram_wren low from the instant reset asserts.
    always_comb begin
        ram_wren = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StCapture: busy = 1'b1;
            StWrite: begin
                busy     = 1'b1;
                ram_wren = 1'b1;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            decim_q <= '0;
            addr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    // A pop coincident with start is deliberately not counted.
                    if (start) begin
                        decim_q <= '0;
                        addr_q  <= '0;
                        count_q <= '0;
                    end
                end
                StCapture: begin
                    if (window_end) begin
                        data_q  <= quant;
                        decim_q <= '0;
                    end else if (pop) begin
                        decim_q <= decim_q + 1'b1;
                    end
                end
                StWrite: begin
                    count_q <= count_q + 1'b1;
                    if (addr_q != ADDR_LAST) begin
                        addr_q <= addr_q + 1'b1;
                    end
                    // A pop in the write cycle opens the next decimation window.
                    decim_q <= pop ? CNT_W'(1) : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_recorder.sv
// Self-checking bench for audio_recorder: a cycle model pushes expected RAM writes into
// a scoreboard which is popped and compared when the DUT asserts ram_wren.
module tb_audio_recorder;
    import trumpet_pkg::*;

    localparam int unsigned ADDR_W = DEF_ADDR_W;
    localparam int unsigned DATA_W = DEF_DATA_W;
    localparam int unsigned DEPTH  = DEF_DEPTH;
    localparam int unsigned DECIM  = DEF_DECIM;

`ifdef AUDIO_RECORDER_ROUND_EN
    localparam logic [DATA_W-1:0] EXP_MAXPOS = 3'b011;
    localparam logic [DATA_W-1:0] EXP_0X3    = 3'b010;
`else
    localparam logic [DATA_W-1:0] EXP_MAXPOS = 3'b011;
    localparam logic [DATA_W-1:0] EXP_0X3    = 3'b001;
`endif

    logic              CLOCK_50 = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              audio_in_available = 1'b0;
    logic [31:0]       left_channel_audio_in = '0;
    logic              read_audio_in;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] sample_count;

    audio_recorder dut (
        .CLOCK_50              (CLOCK_50),
        .reset_n               (reset_n),
        .start                 (start),
        .audio_in_available    (audio_in_available),
        .left_channel_audio_in (left_channel_audio_in),
        .read_audio_in         (read_audio_in),
        .ram_address           (ram_address),
        .ram_data              (ram_data),
        .ram_wren              (ram_wren),
        .busy                  (busy),
        .done                  (done),
        .sample_count          (sample_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] q_model(input logic [31:0] s);
`ifdef AUDIO_RECORDER_ROUND_EN
        longint v;
        v = longint'($signed(s)) + (longint'(1) << (31 - DATA_W));
        if (v > longint'(32'h7FFF_FFFF)) return {1'b0, {(DATA_W-1){1'b1}}};
        return v[31:32-DATA_W];
`else
        return s[31:32-DATA_W];
`endif
    endfunction

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t sb[$];
    wr_t log_q[$];

    logic              m_busy, m_done, m_wpend;
    int                m_cnt;
    logic [ADDR_W-1:0] m_addr, m_count;

    // Reference behaviour of the recorder, advanced on the same edges as the DUT.
    always @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_wpend <= 1'b0;
            m_cnt   <= 0;
            m_addr  <= '0;
            m_count <= '0;
            sb.delete();
        end else if (m_wpend) begin
            m_wpend <= 1'b0;
            m_count <= m_count + 1'b1;
            if (m_addr == ADDR_W'(DEPTH - 1)) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end else begin
                m_addr <= m_addr + 1'b1;
            end
            m_cnt <= audio_in_available ? 1 : 0;
        end else if (m_busy) begin
            if (audio_in_available) begin
                if (m_cnt == DECIM - 1) begin
                    sb.push_back({m_addr, q_model(left_channel_audio_in)});
                    m_wpend <= 1'b1;
                    m_cnt   <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end else if (start) begin
            m_busy  <= 1'b1;
            m_done  <= 1'b0;
            m_cnt   <= 0;
            m_addr  <= '0;
            m_count <= '0;
        end
    end

    int                wr_count = 0;
    logic [ADDR_W-1:0] last_addr = '0;

    always @(negedge CLOCK_50) begin
        wr_t e;
        if (reset_n && (ram_wren || m_wpend)) begin
            check("wren", 32'(ram_wren), 32'(m_wpend));
            if (m_wpend && sb.size() > 0) e = sb.pop_front();
            if (ram_wren) begin
                wr_count++;
                last_addr = ram_address;
                log_q.push_back({ram_address, ram_data});
                check("wr_busy", 32'(busy), 32'd1);
                check("wr_done", 32'(done), 32'd0);
                check("wr_count", 32'(sample_count), 32'(m_count));
                if (m_wpend) begin
                    check("wr_addr", 32'(ram_address), 32'(e.addr));
                    check("wr_data", 32'(ram_data), 32'(e.data));
                end
            end
        end
    end

    task automatic cyc(input logic a, input logic s, input logic [31:0] d);
        audio_in_available    = a;
        start                 = s;
        left_channel_audio_in = d;
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tbl [12];
        int          w0;
        int          guard;
        tbl = '{32'h2000_0000, 32'h4000_0000, 32'h6000_0000, 32'h8000_0000,
                32'hA000_0000, 32'hC000_0000, 32'h1234_5678, 32'h2000_0000,
                32'h4000_0000, 32'h6000_0000, 32'h8000_0000, 32'hE000_0000};

        // Reset state
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_wren", 32'(ram_wren), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr", 32'(ram_address), 0);
        check("rst_data", 32'(ram_data), 0);
        check("rst_count", 32'(sample_count), 0);
        check("rst_read", 32'(read_audio_in), 0);
        reset_n = 1'b1;
        @(posedge CLOCK_50);
        #1;

        // FIFO drained while idle, nothing written
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, $urandom);
            check("idle_read", 32'(read_audio_in), 1);
            check("idle_wren", 32'(ram_wren), 0);
        end
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);

        // Twelve back-to-back pops -> two writes
        cyc(1'b0, 1'b1, 32'h0);
        check("start_busy", 32'(busy), 1);
        log_q.delete();
        w0 = wr_count;
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, tbl[i]);
        repeat (3) cyc(1'b0, 1'b0, 32'h0);
        check("twelve_nwr", 32'(wr_count - w0), 2);
        check("twelve_count", 32'(sample_count), 2);
        check("twelve_logged", 32'(log_q.size()), 2);
        if (log_q.size() >= 2) begin
            check("twelve_a0", 32'(log_q[0].addr), 0);
            check("twelve_d0", 32'(log_q[0].data), 32'b110);
            check("twelve_a1", 32'(log_q[1].addr), 1);
            check("twelve_d1", 32'(log_q[1].data), 32'b111);
        end

        // Full take; start pulsed during write #10 must be ignored
        reset_n = 1'b0;
        cyc(1'b0, 1'b0, 32'h0);
        reset_n = 1'b1;
        cyc(1'b0, 1'b1, 32'h0);
        w0 = wr_count;
        guard = 0;
        while (!done && guard < 40000) begin
            cyc(1'b1, (ram_wren && (wr_count - w0 == 9)), $urandom);
            guard++;
        end
        check("full_timeout", 32'(guard < 40000), 1);
        check("full_done", 32'(done), 1);
        check("full_busy", 32'(busy), 0);
        check("full_count", 32'(sample_count), DEPTH);
        check("full_nwr", 32'(wr_count - w0), DEPTH);
        check("full_last", 32'(last_addr), DEPTH - 1);
        check("full_addr_hold", 32'(ram_address), DEPTH - 1);
        w0 = wr_count;
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, $urandom);
        check("after_nwr", 32'(wr_count - w0), 0);
        check("after_done", 32'(done), 1);

        // Restart from DONE, then reset while a write is in flight
        cyc(1'b0, 1'b1, 32'h0);
        check("restart_done", 32'(done), 0);
        guard = 0;
        while (!ram_wren && guard < 20) begin
            cyc(1'b1, 1'b0, $urandom);
            guard++;
        end
        check("midrst_reach_wr", 32'(ram_wren), 1);
        reset_n = 1'b0;
        #1;
        check("midrst_wren", 32'(ram_wren), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_addr", 32'(ram_address), 0);
        check("midrst_data", 32'(ram_data), 0);
        check("midrst_count", 32'(sample_count), 0);
        @(posedge CLOCK_50);
        #1;
        reset_n = 1'b1;

        // Pop coincident with start is dropped; pop in WRITE counts for the next window
        log_q.delete();
        cyc(1'b1, 1'b1, 32'h1111_1111);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, $urandom);
        check("coinc_nowr", 32'(ram_wren), 0);
        cyc(1'b1, 1'b0, 32'h7FFF_FFFF);
        check("win1_wren", 32'(ram_wren), 1);
        check("win1_addr", 32'(ram_address), 0);
        check("q_maxpos", 32'(ram_data), 32'(EXP_MAXPOS));
        cyc(1'b1, 1'b0, $urandom);
        check("wrpop_wren", 32'(ram_wren), 0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, $urandom);
        check("win2_early", 32'(ram_wren), 0);
        cyc(1'b1, 1'b0, 32'h3000_0000);
        check("win2_wren", 32'(ram_wren), 1);
        check("win2_addr", 32'(ram_address), 1);
        check("q_0x3", 32'(ram_data), 32'(EXP_0X3));
        cyc(1'b0, 1'b0, 32'h0);
        check("win2_count", 32'(sample_count), 2);
        check("restart_logged", 32'(log_q.size()), 2);
        if (log_q.size() >= 1) check("restart_addr0", 32'(log_q[0].addr), 0);
        repeat (2) cyc(1'b0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
